// File: rtl/data_bus_unit.sv
// Load/store bus interface: turns decoder strobes into a valid/ready data-memory
// transaction, stalls the core while it is pending and returns extended load data.
module data_bus_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_read,
  input  logic        i_bus_write,
  input  logic        i_bus_to_reg,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_access_fault,
  output logic        o_mem_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_req;
  logic        w_legal;
  logic        w_aligned;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_stall;

  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_access_fault;
  logic [2:0]  r_funct3;
  logic [1:0]  r_ofs;

  // Lane-align the returned word and extend it according to the latched funct3.
  function automatic logic [31:0] f_load_ext(input logic [31:0] data,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  ofs);
    logic [31:0] sh;
    sh = data >> {ofs, 3'b000};
    case (f3)
      3'b000:  f_load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  f_load_ext = {24'h000000, sh[7:0]};
      3'b001:  f_load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  f_load_ext = {16'h0000, sh[15:0]};
      default: f_load_ext = sh;
    endcase
  endfunction

  // Decode the request: size legality (bit 2 only matters for loads), alignment, lanes.
  always_comb begin
    w_req     = i_bus_write | (i_bus_read & i_bus_to_reg);
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_be      = 4'b0000;
    w_wdata   = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_legal   = 1'b1;
        w_aligned = ~i_addr[0];
        w_be      = 4'b0011 << i_addr[1:0];
        w_wdata   = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        w_legal   = i_bus_write | ~i_funct3[2];
        w_aligned = (i_addr[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
    w_go = w_req & w_legal & w_aligned;
  end

  // Next-state logic and the combinational stall back to the pipeline.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next  = S_ACCESS;
          w_stall = ~i_rst;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_stall = ~i_rst;
        if (i_mem_ready) begin
          w_next = S_DONE;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bus request registers, fault pulse and load-data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_valid    <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 32'h0000_0000;
      r_mem_be       <= 4'b0000;
      r_mem_wdata    <= 32'h0000_0000;
      r_rdata        <= 32'h0000_0000;
      r_access_fault <= 1'b0;
      r_funct3       <= 3'b000;
      r_ofs          <= 2'b00;
    end else begin
      r_access_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= i_bus_write;
            r_mem_addr  <= {i_addr[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_funct3    <= i_funct3;
            r_ofs       <= i_addr[1:0];
          end else if (w_req) begin
            r_access_fault <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            if (!r_mem_we) begin
              r_rdata <= f_load_ext(i_mem_rdata, r_funct3, r_ofs);
            end
          end
        end
        S_DONE:  r_mem_valid <= 1'b0;
        default: r_mem_valid <= 1'b0;
      endcase
    end
  end

  assign o_rdata        = r_rdata;
  assign o_stall        = w_stall;
  assign o_access_fault = r_access_fault;
  assign o_mem_valid    = r_mem_valid;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_be       = r_mem_be;
  assign o_mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_data_bus_unit.sv
// Bench for data_bus_unit: directed vector table, randomized transactions against
// an arithmetic reference model, and a reset-during-access sequence.
module tb_data_bus_unit;

  logic        clk;
  logic        rst;
  logic        bus_read;
  logic        bus_write;
  logic        bus_to_reg;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_fault;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  data_bus_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_bus_read     (bus_read),
    .i_bus_write    (bus_write),
    .i_bus_to_reg   (bus_to_reg),
    .i_funct3       (funct3),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_stall        (stall),
    .o_access_fault (access_fault),
    .o_mem_valid    (mem_valid),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_be       (mem_be),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata),
    .i_mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        bw;
    logic        btr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          waits;
    logic        go;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    bus_to_reg = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    wdata      = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // Reference model from the access rules: size in bytes, modulo alignment, arithmetic lanes.
  task automatic model(input logic br, input logic bw, input logic btr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                       output logic go, output logic fault, output logic [3:0] be,
                       output logic [31:0] mwd, output logic [31:0] ld);
    int unsigned n;
    int unsigned ofs;
    logic        req;
    logic [63:0] mask;
    logic [63:0] v;
    n = 0;
    if (bw) begin
      if (f3 % 4 == 0) n = 1;
      else if (f3 % 4 == 1) n = 2;
      else if (f3 % 4 == 2) n = 4;
    end else begin
      if (f3 == 0 || f3 == 4) n = 1;
      else if (f3 == 1 || f3 == 5) n = 2;
      else if (f3 == 2) n = 4;
    end
    ofs   = a % 4;
    req   = bw | (br & btr);
    go    = req && (n != 0) && (a % n == 0);
    fault = req && !go;
    be    = 4'b0000;
    mwd   = wd;
    ld    = 32'h0;
    if (go) begin
      be = 4'(((1 << n) - 1) << ofs);
      if (n == 1) mwd = (wd % 256) * 32'h0101_0101;
      else if (n == 2) mwd = (wd % 65536) * 32'h0001_0001;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = {32'h0, mrd} / (64'd1 << (8 * ofs));
      v    = v & mask;
      if (n < 4 && f3 < 4 && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      ld = v[31:0];
    end
  endtask

  // Presents one instruction and follows it to completion, checking every cycle.
  task automatic run_txn(input string nm, input logic br, input logic bw, input logic btr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mrd, input int waits, input logic ego,
                         input logic efault, input logic [3:0] ebe, input logic [31:0] emwd,
                         input logic [31:0] erd);
    @(posedge clk); #1;
    bus_read = br; bus_write = bw; bus_to_reg = btr;
    funct3 = f3; addr = a; wdata = wd;
    mem_ready = !ego;
    mem_rdata = ~mrd;
    @(negedge clk);
    chk({nm, " stall_req"}, stall, ego);
    chk({nm, " valid_req"}, mem_valid, 1'b0);
    if (ego) begin
      for (int w = 0; w <= waits; w++) begin
        @(posedge clk); #1;
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? mrd : ~mrd;
        @(negedge clk);
        chk({nm, " valid"}, mem_valid, 1'b1);
        chk({nm, " stall"}, stall, 1'b1);
        chk({nm, " addr"}, mem_addr, {a[31:2], 2'b00});
        chk({nm, " be"}, mem_be, ebe);
        chk({nm, " we"}, mem_we, bw);
        if (bw) chk({nm, " wdata"}, mem_wdata, emwd);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk({nm, " stall_done"}, stall, 1'b0);
      chk({nm, " valid_done"}, mem_valid, 1'b0);
      chk({nm, " rdata"}, rdata, erd);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk({nm, " stall_idle"}, stall, 1'b0);
    end else begin
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk({nm, " fault"}, access_fault, efault);
      chk({nm, " stall_n1"}, stall, 1'b0);
      chk({nm, " valid_n1"}, mem_valid, 1'b0);
      chk({nm, " rdata_hold"}, rdata, erd);
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, " fault_end"}, access_fault, 1'b0);
    end
  endtask

  initial begin
    logic        go;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] ld;
    logic [31:0] model_rd;
    logic        br;
    logic        bw;
    logic        btr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mrd;

    //            br    bw    btr   f3      addr          wdata         mem_rdata     w  go    flt   be       mwdata        rdata
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h1234_5678, 0, 1'b1, 1'b0, 4'b1111, 32'h0,        32'h1234_5678};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b1, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b1, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 0, 1'b1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h1111_1111, 3, 1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0080};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7777, 0, 1'b1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 1'b1, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,         0, 1'b1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_F00D};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b110, 32'h0000_0010, 32'h0102_0304, 32'h9999_9999, 0, 1'b1, 1'b0, 4'b1111, 32'h0102_0304, 32'h0000_F00D};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'b111, 32'h0000_0010, 32'h0,        32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0000_F00D};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0000_F00D};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 1, 1'b1, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D};

    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_in_rst", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst valid", mem_valid, 1'b0);
    chk("rst we", mem_we, 1'b0);
    chk("rst fault", access_fault, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst be", mem_be, 4'b0000);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst rdata", rdata, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].br, vecs[i].bw, vecs[i].btr, vecs[i].f3,
              vecs[i].a, vecs[i].wd, vecs[i].mrd, vecs[i].waits, vecs[i].go,
              vecs[i].fault, vecs[i].be, vecs[i].mwd, vecs[i].rd);
    end

    model_rd = 32'hCAFE_F00D;
    for (int i = 0; i < 60; i++) begin
      br  = 1'($urandom_range(0, 1));
      bw  = ($urandom_range(0, 3) == 0);
      btr = ($urandom_range(0, 3) != 0);
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      wd  = $urandom;
      mrd = $urandom;
      model(br, bw, btr, f3, a, wd, mrd, go, fault, be, mwd, ld);
      if (go && !bw) model_rd = ld;
      run_txn($sformatf("rnd%0d", i), br, bw, btr, f3, a, wd, mrd,
              int'($urandom_range(0, 2)), go, fault, be, mwd, model_rd);
    end

    // Reset while a load waits in ACCESS, then a stray ready for the abandoned request.
    @(posedge clk); #1;
    bus_read = 1'b1; bus_to_reg = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid valid_before", mem_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid stall_in_rst", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rstmid valid", mem_valid, 1'b0);
    chk("rstmid rdata", rdata, 32'h0);
    chk("rstmid stall", stall, 1'b0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid stray valid", mem_valid, 1'b0);
    chk("rstmid stray rdata", rdata, 32'h0);
    chk("rstmid stray stall", stall, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
